trap_scan: RTL
==============

# trap_scan

Per-frame collision scanner that sits directly upstream of the game state machine and produces its `man_collide_trap` and `level_complete` inputs. At each frame start it snapshots the player position and walks the trap table one entry per cycle. It tests each valid trap box against the player box, tests the goal box once, and reports the result as single-cycle pulses at the end of the scan.

## Interface
Parameters:
- `NUM_TRAPS`, 16: trap table depth; power of two, ≥2.
- `COORD_W`, 10: pixel coordinate width.
- `MAN_W`, 16: player box width in pixels.
- `MAN_H`, 16: player box height in pixels.
- `TRAP_W`, 16: trap box width in pixels.
- `TRAP_H`, 16: trap box height in pixels.
- `GOAL_W`, 16: goal box width in pixels.
- `GOAL_H`, 32: goal box height in pixels.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort/clear; driven from the game state `reset` output.
- `frame_start`  in  1  one-cycle pulse per frame (vsync edge).
- `man_x`, `man_y`  in  COORD_W  player top-left corner.
- `goal_x`, `goal_y`  in  COORD_W  goal top-left corner; stable during a scan.
- `trap_addr`  out  $clog2(NUM_TRAPS)  trap table read address.
- `trap_x`, `trap_y`  in  COORD_W  trap top-left corner; 1-cycle read latency.
- `trap_valid`  in  1  table entry is active; 1-cycle read latency.
- `man_collide_trap`  out  1  pulse: the player overlapped at least one valid trap this frame.
- `level_complete`  out  1  pulse: the player overlapped the goal this frame.
- `hit_idx`  out  $clog2(NUM_TRAPS)  lowest index of a hit trap; held until the next report.
- `busy`  out  1  a scan is in progress.
- `overrun`  out  1  sticky flag: a `frame_start` arrived while busy.

## Operation
- FSM states: IDLE, SCAN, REPORT.
- **IDLE:**
  - `frame_start` latches `man_x`/`man_y` into snapshot registers.
  - Clears the hit accumulators.
  - Sets `trap_addr` to 0 and moves to SCAN.
- **SCAN:**
  - Issues addresses 0..NUM_TRAPS-1 on consecutive cycles.
  - Data for address k is compared one cycle later; a valid-data flag pipelines alongside the address.
  - A trap hit requires `trap_valid`=1 and overlap.
  - On the first hit, `hit_idx` takes that index; later hits do not change it.
  - The goal comparison uses the snapshot and is done once during SCAN.
  - When the last entry's compare has completed, the FSM moves to REPORT.
- **REPORT:**
  - Drives `man_collide_trap` and `level_complete` high for exactly one cycle from the accumulators.
  - Returns to IDLE.
- **Overlap rule (strict; touching edges do not count):** `ax < bx+bw` and `bx < ax+aw`, and the same on y.
  - Sums are computed in COORD_W+1 bits, so there is no wrap at the screen edge.
- **Simultaneous events:**
  - A trap hit and a goal hit in the same frame pulse both outputs in the same cycle; the downstream FSM gives the trap priority.
  - `frame_start` while busy is ignored; the current scan is unaffected and `overrun` is set. `overrun` is cleared only by `rst_n` or `clr`.
  - `frame_start` in the same cycle as REPORT is also ignored and sets `overrun`.
- **`clr`:**
  - Valid in any state: returns to IDLE and zeroes the accumulators, `hit_idx` and `overrun`.
  - No report is produced for an aborted scan.
  - `clr` has priority over `frame_start`.
- **Reset:** every output is 0 (`trap_addr`, `hit_idx`, `busy`, `overrun`, both pulses) and the FSM is in IDLE. Reset mid-scan discards the scan.

## Timing
- `frame_start` sampled at cycle 0: SCAN occupies cycles 1..NUM_TRAPS+1 and REPORT is cycle NUM_TRAPS+2.
  - With NUM_TRAPS=16, the pulses appear 18 cycles after `frame_start`.
- `busy` is high from cycle 1 through the REPORT cycle inclusive.
- `trap_addr` = k on cycle k+1; `trap_x`/`trap_y`/`trap_valid` are sampled on cycle k+2.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The minimum frame period is NUM_TRAPS+3 cycles; a shorter period causes overrun.

## Structure
- Shared package `game_pkg`:
  - `COORD_W` and the box size constants.
  - `trap_entry_t` struct {valid, x, y}.
  - The `scan_state_t` enum (IDLE, SCAN, REPORT).
- Sub-module `aabb_overlap`: purely combinational, parameterised by the two box sizes, producing one bit.
  - Instantiated twice: player vs trap, and player vs goal.

## Test plan
- Trap 5 at (100,100) valid, player at (108,92), all other entries invalid, goal far away → 18 cycles after `frame_start`: `man_collide_trap`=1 for one cycle, `hit_idx`=5, `level_complete`=0.
- Player at (116,100) vs trap at (100,100), edges touching → no pulse; at (115,100) → pulse.
- Traps 3 and 9 both overlap, trap 9 marked invalid → `hit_idx`=3; trap 3 made invalid too → no pulse.
- Goal at (200,50), player at (205,70), trap 0 also overlapping → both pulses in the same cycle.
- `frame_start` again at cycle 6 of a scan → ignored, `overrun`=1, report still at cycle 18; `clr` at cycle 10 of the next scan → no report, `overrun`=0, `busy`=0 next cycle.
- Player at (1015,1015) with COORD_W=10 vs a trap at (5,5) → no false hit from wrap.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, trap table entry layout and scanner state encoding.
package game_pkg;

    localparam int COORD_W   = 10;
    localparam int NUM_TRAPS = 16;
    localparam int MAN_W     = 16;
    localparam int MAN_H     = 16;
    localparam int TRAP_W    = 16;
    localparam int TRAP_H    = 16;
    localparam int GOAL_W    = 16;
    localparam int GOAL_H    = 32;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } trap_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } scan_state_t;

endpackage

// File: rtl/aabb_overlap.sv
// Strict axis-aligned box overlap test; edges that only touch do not count.
module aabb_overlap #(
    parameter int COORD_W = 10,
    parameter int A_W     = 16,
    parameter int A_H     = 16,
    parameter int B_W     = 16,
    parameter int B_H     = 16
) (
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    output logic               hit
);

    localparam int SW = COORD_W + 1;

    // One extra bit so a box hugging the screen edge does not wrap to 0.
    logic [SW-1:0] ax_e, ay_e, bx_e, by_e;
    logic [SW-1:0] ax_end, ay_end, bx_end, by_end;

    assign ax_e   = {1'b0, ax};
    assign ay_e   = {1'b0, ay};
    assign bx_e   = {1'b0, bx};
    assign by_e   = {1'b0, by};
    assign ax_end = ax_e + SW'(A_W);
    assign ay_end = ay_e + SW'(A_H);
    assign bx_end = bx_e + SW'(B_W);
    assign by_end = by_e + SW'(B_H);

    assign hit = (ax_e < bx_end) && (bx_e < ax_end) &&
                 (ay_e < by_end) && (by_e < ay_end);

endmodule

// File: rtl/trap_scan.sv
// Per-frame scanner: walks the trap table once per frame and pulses the
// trap-collision and level-complete results to the game state machine.
module trap_scan #(
    parameter int NUM_TRAPS = game_pkg::NUM_TRAPS,
    parameter int COORD_W   = game_pkg::COORD_W,
    parameter int MAN_W     = game_pkg::MAN_W,
    parameter int MAN_H     = game_pkg::MAN_H,
    parameter int TRAP_W    = game_pkg::TRAP_W,
    parameter int TRAP_H    = game_pkg::TRAP_H,
    parameter int GOAL_W    = game_pkg::GOAL_W,
    parameter int GOAL_H    = game_pkg::GOAL_H
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         frame_start,
    input  logic [COORD_W-1:0]           man_x,
    input  logic [COORD_W-1:0]           man_y,
    input  logic [COORD_W-1:0]           goal_x,
    input  logic [COORD_W-1:0]           goal_y,
    output logic [$clog2(NUM_TRAPS)-1:0] trap_addr,
    input  logic [COORD_W-1:0]           trap_x,
    input  logic [COORD_W-1:0]           trap_y,
    input  logic                         trap_valid,
    output logic                         man_collide_trap,
    output logic                         level_complete,
    output logic [$clog2(NUM_TRAPS)-1:0] hit_idx,
    output logic                         busy,
    output logic                         overrun
);

    import game_pkg::*;

    localparam int                IDX_W = $clog2(NUM_TRAPS);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_TRAPS - 1);

    scan_state_t        state, state_next;
    logic [COORD_W-1:0] snap_x, snap_y;
    logic               issue;
    logic               rd_vld;
    logic [IDX_W-1:0]   rd_idx;
    logic               trap_acc;
    logic [IDX_W-1:0]   first_idx;
    logic               trap_ovl, goal_ovl;
    logic               trap_hit_now, last_cmp, any_hit;

    aabb_overlap #(
        .COORD_W(COORD_W), .A_W(MAN_W), .A_H(MAN_H), .B_W(TRAP_W), .B_H(TRAP_H)
    ) u_trap_ovl (
        .ax(snap_x), .ay(snap_y), .bx(trap_x), .by(trap_y), .hit(trap_ovl)
    );

    aabb_overlap #(
        .COORD_W(COORD_W), .A_W(MAN_W), .A_H(MAN_H), .B_W(GOAL_W), .B_H(GOAL_H)
    ) u_goal_ovl (
        .ax(snap_x), .ay(snap_y), .bx(goal_x), .by(goal_y), .hit(goal_ovl)
    );

    // rd_vld/rd_idx describe the table data arriving this cycle (one behind trap_addr).
    assign trap_hit_now = rd_vld && trap_valid && trap_ovl;
    assign last_cmp     = rd_vld && (rd_idx == LAST);
    assign any_hit      = trap_acc || trap_hit_now;

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (frame_start) state_next = SCAN;
            SCAN:    if (last_cmp)    state_next = REPORT;
            REPORT:                   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_x           <= '0;
            snap_y           <= '0;
            trap_addr        <= '0;
            issue            <= 1'b0;
            rd_vld           <= 1'b0;
            rd_idx           <= '0;
            trap_acc         <= 1'b0;
            first_idx        <= '0;
            hit_idx          <= '0;
            man_collide_trap <= 1'b0;
            level_complete   <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
        end else if (clr) begin
            trap_addr        <= '0;
            issue            <= 1'b0;
            rd_vld           <= 1'b0;
            trap_acc         <= 1'b0;
            first_idx        <= '0;
            hit_idx          <= '0;
            man_collide_trap <= 1'b0;
            level_complete   <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            man_collide_trap <= 1'b0;
            level_complete   <= 1'b0;
            busy             <= (state_next != IDLE);
            rd_vld           <= issue;
            rd_idx           <= trap_addr;
            if (frame_start && state != IDLE) overrun <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        snap_x    <= man_x;
                        snap_y    <= man_y;
                        trap_addr <= '0;
                        issue     <= 1'b1;
                        trap_acc  <= 1'b0;
                        first_idx <= '0;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (trap_addr == LAST) issue     <= 1'b0;
                        else                   trap_addr <= trap_addr + 1'b1;
                    end
                    if (trap_hit_now && !trap_acc) first_idx <= rd_idx;
                    if (trap_hit_now)              trap_acc  <= 1'b1;
                    // Results land in the output registers so the pulses appear in REPORT.
                    if (last_cmp) begin
                        man_collide_trap <= any_hit;
                        level_complete   <= goal_ovl;
                        if (any_hit) hit_idx <= trap_acc ? first_idx : rd_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
